// File: rtl/clint_rd_arbiter.sv
// rtl/clint_rd_arbiter.sv - round-robin two-master AXI4 read-channel arbiter, one burst in flight
module clint_rd_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           m0_arvalid,
  output logic           m0_arready,
  input  logic [AW-1:0]  m0_araddr,
  input  logic [7:0]     m0_arlen,
  output logic           m0_rvalid,
  input  logic           m0_rready,
  output logic [DW-1:0]  m0_rdata,
  output logic           m0_rlast,

  input  logic           m1_arvalid,
  output logic           m1_arready,
  input  logic [AW-1:0]  m1_araddr,
  input  logic [7:0]     m1_arlen,
  output logic           m1_rvalid,
  input  logic           m1_rready,
  output logic [DW-1:0]  m1_rdata,
  output logic           m1_rlast,

  output logic           s_arvalid,
  input  logic           s_arready,
  output logic [AW-1:0]  s_araddr,
  output logic [7:0]     s_arlen,
  output logic [IDW-1:0] s_arid,
  input  logic           s_rvalid,
  output logic           s_rready,
  input  logic [DW-1:0]  s_rdata,
  input  logic           s_rlast,
  input  logic [IDW-1:0] s_rid,

  output logic           rd_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;

  logic [1:0]    state;
  logic          last_grant;
  logic          gnt_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_cnt;

  logic in_idle, in_ar, in_r;
  logic any_req, winner;
  logic beat_hs;
  logic err_early, err_late, err_id;

  assign in_idle = (state == ST_IDLE);
  assign in_ar   = (state == ST_AR);
  assign in_r    = (state == ST_R);

  // On a tie the master that did not win last time takes the grant.
  assign any_req = m0_arvalid | m1_arvalid;
  always_comb begin
    winner = 1'b0;
    if (m0_arvalid && m1_arvalid) begin
      winner = ~last_grant;
    end else begin
      winner = m1_arvalid;
    end
  end

  // Gating with rst keeps the address accepts quiet while reset is held.
  assign m0_arready = rst & in_idle & any_req & ~winner;
  assign m1_arready = rst & in_idle & any_req &  winner;

  assign s_arvalid = in_ar;
  assign s_araddr  = in_ar ? addr_q : '0;
  assign s_arlen   = in_ar ? len_q  : '0;
  assign s_arid    = in_ar ? IDW'(gnt_q) : '0;

  assign s_rready  = in_r & (gnt_q ? m1_rready : m0_rready);

  assign m0_rvalid = in_r & ~gnt_q & s_rvalid;
  assign m0_rlast  = in_r & ~gnt_q & s_rlast;
  assign m0_rdata  = (in_r && !gnt_q) ? s_rdata : '0;
  assign m1_rvalid = in_r &  gnt_q & s_rvalid;
  assign m1_rlast  = in_r &  gnt_q & s_rlast;
  assign m1_rdata  = (in_r && gnt_q) ? s_rdata : '0;

  assign beat_hs   = in_r & s_rvalid & s_rready;
  assign err_early = beat_hs &  s_rlast & (beat_cnt != len_q);
  assign err_late  = beat_hs & ~s_rlast & (beat_cnt == len_q);
  assign err_id    = beat_hs & (s_rid != IDW'(gnt_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b0;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q    <= winner;
            addr_q   <= winner ? m1_araddr : m0_araddr;
            len_q    <= winner ? m1_arlen  : m0_arlen;
            beat_cnt <= '0;
            state    <= ST_AR;
          end
        end
        ST_AR: begin
          if (s_arready) begin
            state <= ST_R;
          end
        end
        ST_R: begin
          if (beat_hs) begin
            // Saturate so a runaway slave cannot wrap the count back to a legal value.
            if (beat_cnt != 8'hFF) begin
              beat_cnt <= beat_cnt + 8'd1;
            end
            if (s_rlast) begin
              last_grant <= gnt_q;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Errors are sticky; forwarding is never blocked by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_err <= 1'b0;
    end else if (err_early || err_late || err_id) begin
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clint_rd_arbiter.sv
// tb/tb_clint_rd_arbiter.sv - directed vector bench for clint_rd_arbiter
module tb_clint_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_arvalid = 0, m1_arvalid = 0;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_araddr = 0, m1_araddr = 0;
  logic [7:0]  m0_arlen = 0, m1_arlen = 0;
  logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic        m0_rready = 0, m1_rready = 0;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_arvalid, s_rready, rd_err;
  logic        s_arready = 0;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [3:0]  s_arid;
  logic        s_rvalid = 0, s_rlast = 0;
  logic [63:0] s_rdata = 0;
  logic [3:0]  s_rid = 0;

  int total = 0;
  int bad   = 0;

  clint_rd_arbiter #(.AW(32), .DW(64), .IDW(4)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rid(s_rid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1, input logic exp_idx);
    m0_arvalid = v0; m1_arvalid = v1;
    m0_araddr = a0; m1_araddr = a1; m0_arlen = l0; m1_arlen = l1;
    #1;
    chk("grant_m0_arready", m0_arready, !exp_idx);
    chk("grant_m1_arready", m1_arready, exp_idx);
    tick();
    m0_arvalid = 0; m1_arvalid = 0;
    #1;
    chk("ar_s_arvalid", s_arvalid, 1);
    chk("ar_s_arid", s_arid, {3'b0, exp_idx});
    chk("ar_s_araddr", s_araddr, exp_idx ? a1 : a0);
    chk("ar_s_arlen", s_arlen, exp_idx ? l1 : l0);
    chk("ar_m0_arready_low", m0_arready, 0);
    s_arready = 1;
    tick();
    s_arready = 0;
  endtask

  task automatic beat(input logic idx, input logic [63:0] data, input logic last, input logic [3:0] rid);
    s_rvalid = 1; s_rdata = data; s_rlast = last; s_rid = rid;
    m0_rready = 1; m1_rready = 1;
    #1;
    chk("beat_granted_rvalid", idx ? m1_rvalid : m0_rvalid, 1);
    chk("beat_other_rvalid", idx ? m0_rvalid : m1_rvalid, 0);
    chk("beat_rdata", idx ? m1_rdata : m0_rdata, data);
    chk("beat_rlast", idx ? m1_rlast : m0_rlast, last);
    chk("beat_s_rready", s_rready, 1);
    tick();
    s_rvalid = 0; s_rlast = 0; s_rdata = 0; s_rid = 0;
    m0_rready = 0; m1_rready = 0;
  endtask

  task automatic idle_probe(input string name);
    m0_arvalid = 1;
    #1;
    chk(name, m0_arready, 1);
    m0_arvalid = 0;
  endtask

  typedef struct {
    logic v0, v1;
    logic e0, e1;
  } gvec_t;

  typedef struct {
    logic       v0, v1;
    logic       exp_idx;
    logic [63:0] data;
  } txn_t;

  gvec_t gv[4];
  txn_t  tv[7];

  initial begin
    gv[0] = '{v0:0, v1:0, e0:0, e1:0};
    gv[1] = '{v0:1, v1:0, e0:1, e1:0};
    gv[2] = '{v0:0, v1:1, e0:0, e1:1};
    gv[3] = '{v0:1, v1:1, e0:0, e1:1};

    tv[0] = '{v0:1, v1:1, exp_idx:1, data:64'hA000};
    tv[1] = '{v0:1, v1:1, exp_idx:0, data:64'hA001};
    tv[2] = '{v0:1, v1:1, exp_idx:1, data:64'hA002};
    tv[3] = '{v0:1, v1:1, exp_idx:0, data:64'hA003};
    tv[4] = '{v0:0, v1:1, exp_idx:1, data:64'hA004};
    tv[5] = '{v0:0, v1:1, exp_idx:1, data:64'hA005};
    tv[6] = '{v0:1, v1:1, exp_idx:0, data:64'hA006};

    // reset state with both masters requesting
    m0_arvalid = 1; m1_arvalid = 1; s_rvalid = 1;
    @(posedge clk); #1;
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_arid", s_arid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_rd_err", rd_err, 0);
    m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0;
    rst = 1;
    tick();

    // combinational grant in IDLE, never reaching a clock edge
    for (int i = 0; i < 4; i++) begin
      m0_arvalid = gv[i].v0; m1_arvalid = gv[i].v1;
      #1;
      chk($sformatf("gtab%0d_m0", i), m0_arready, gv[i].e0);
      chk($sformatf("gtab%0d_m1", i), m1_arready, gv[i].e1);
      chk($sformatf("gtab%0d_s_arvalid", i), s_arvalid, 0);
      m0_arvalid = 0; m1_arvalid = 0;
      tick();
    end

    // single beat from m0
    do_ar(1, 0, 32'h0200_BFF8, 32'h0, 8'd0, 8'd0, 0);
    beat(0, 64'h1234, 1, 4'd0);
    chk("single_rd_err", rd_err, 0);

    // round-robin table; last_grant is now m0
    for (int i = 0; i < 7; i++) begin
      do_ar(tv[i].v0, tv[i].v1, 32'h1000 + i, 32'h2000 + i, 8'd0, 8'd0, tv[i].exp_idx);
      beat(tv[i].exp_idx, tv[i].data, 1, {3'b0, tv[i].exp_idx});
      chk($sformatf("ttab%0d_rd_err", i), rd_err, 0);
    end

    // m1 four-beat burst with rready toggling
    begin
      int got;
      got = 0;
      do_ar(0, 1, 32'h0, 32'h3000_0000, 8'd0, 8'd3, 1);
      for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
        s_rvalid = 1; s_rdata = 64'hB0 + got; s_rlast = (got == 3); s_rid = 4'd1;
        m1_rready = (cyc % 2 == 0);
        #1;
        chk("burst_m0_rvalid", m0_rvalid, 0);
        chk("burst_m1_rvalid", m1_rvalid, 1);
        chk("burst_m1_rdata", m1_rdata, 64'hB0 + got);
        chk("burst_s_rready", s_rready, (cyc % 2 == 0));
        if (m1_rready) got++;
        tick();
      end
      s_rvalid = 0; s_rlast = 0; m1_rready = 0;
      idle_probe("burst_back_idle");
      chk("burst_rd_err", rd_err, 0);
      tick();
    end

    // AR stall with s_arready low for 5 cycles
    m0_arvalid = 1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd0;
    #1;
    chk("stall_grant", m0_arready, 1);
    tick();
    m1_arvalid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_s_arvalid", s_arvalid, 1);
      chk("stall_s_araddr", s_araddr, 32'h8000_0040);
      chk("stall_m0_arready", m0_arready, 0);
      chk("stall_m1_arready", m1_arready, 0);
      tick();
    end
    m0_arvalid = 0; m1_arvalid = 0;
    s_arready = 1;
    tick();
    s_arready = 0;
    beat(0, 64'h5555, 1, 4'd0);

    // early rlast: arlen=1, rlast on first beat
    do_ar(1, 0, 32'h4000, 32'h0, 8'd1, 8'd0, 0);
    beat(0, 64'hE1, 1, 4'd0);
    chk("early_rd_err", rd_err, 1);
    idle_probe("early_back_idle");
    tick();
    do_ar(1, 0, 32'h4010, 32'h0, 8'd0, 8'd0, 0);
    beat(0, 64'hE2, 1, 4'd0);
    chk("early_rd_err_sticky", rd_err, 1);

    rst = 0;
    #1;
    chk("rst2_rd_err", rd_err, 0);
    tick();
    rst = 1;
    tick();

    // wrong response id
    do_ar(0, 1, 32'h0, 32'h5000, 8'd0, 8'd0, 1);
    beat(1, 64'hE3, 1, 4'd2);
    chk("rid_rd_err", rd_err, 1);
    idle_probe("rid_back_idle");
    tick();

    // reset asserted mid-burst
    do_ar(1, 0, 32'h6000, 32'h0, 8'd3, 8'd0, 0);
    s_rvalid = 1; s_rdata = 64'h77; s_rid = 4'd0; m0_rready = 1;
    #1;
    chk("mid_pre_rvalid", m0_rvalid, 1);
    rst = 0;
    #1;
    chk("mid_rst_m0_rvalid", m0_rvalid, 0);
    chk("mid_rst_m0_rdata", m0_rdata, 0);
    chk("mid_rst_s_rready", s_rready, 0);
    chk("mid_rst_s_arvalid", s_arvalid, 0);
    chk("mid_rst_rd_err", rd_err, 0);
    s_rvalid = 0; s_rdata = 0; m0_rready = 0;
    tick();
    rst = 1;
    tick();
    do_ar(1, 1, 32'h7000, 32'h7100, 8'd0, 8'd0, 1);
    beat(1, 64'h99, 1, 4'd1);
    chk("post_rst_rd_err", rd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
